// File: rtl/wombat_pkg.sv
// Shared constants and types for the wombat ingress parser.
package wombat_pkg;

    // Header field values that qualify an IPv4/UDP frame
    localparam logic [15:0] ETHTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IPPROTO_UDP  = 8'h11;

    // Packet byte offsets of header fields (network order, MSB byte first)
    localparam int ETHTYPE_OFF   = 12;
    localparam int IPPROTO_OFF   = 23;
    localparam int UDP_DPORT_OFF = 36;

    // Bytes per 256-bit beat
    localparam int BEAT_BYTES = 32;

    // Packet length field position inside tuser
    localparam int TUSER_LEN_LSB = 0;
    localparam int TUSER_LEN_MSB = 15;

    // Parser FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR1 = 2'd1,
        ST_BODY = 2'd2
    } rx_state_e;

endpackage

// File: rtl/axis_reg_slice.sv
// Two-entry skid register slice: one cycle of latency, full throughput,
// and an upstream ready that is registered and independent of out_ready.
module axis_reg_slice #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [WIDTH-1:0] out_data_r;
    logic [WIDTH-1:0] skid_data_r;
    logic             out_valid_r;
    logic             skid_valid_r;
    logic             in_ready_r;
    logic             accept_s;
    logic             out_load_s;

    assign accept_s   = in_valid & in_ready_r;
    assign out_load_s = ~out_valid_r | out_ready;

    // Output/skid entries and registered ready; skid drains before new input
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_r   <= '0;
            skid_data_r  <= '0;
            out_valid_r  <= 1'b0;
            skid_valid_r <= 1'b0;
            in_ready_r   <= 1'b0;
        end else begin
            if (out_load_s) begin
                if (skid_valid_r) begin
                    out_data_r  <= skid_data_r;
                    out_valid_r <= 1'b1;
                end else if (accept_s) begin
                    out_data_r  <= in_data;
                    out_valid_r <= 1'b1;
                end else begin
                    out_valid_r <= 1'b0;
                end
                skid_valid_r <= 1'b0;
            end else if (accept_s) begin
                skid_data_r  <= in_data;
                skid_valid_r <= 1'b1;
            end
            // Ready drops only once the skid entry will hold a beat
            in_ready_r <= out_load_s | ~(accept_s | skid_valid_r);
        end
    end

    assign in_ready  = in_ready_r;
    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;

endmodule

// File: rtl/wombat_rx_parser.sv
// Ingress parser ahead of wombat: passes packets through a register slice,
// picks out a big-endian value from matching Ethernet/IPv4/UDP frames and
// counts packets and matches.
module wombat_rx_parser
    import wombat_pkg::*;
#(
    parameter int          C_S_AXIS_DATA_WIDTH  = 256,
    parameter int          C_S_AXIS_TUSER_WIDTH = 128,
    parameter int          VALUE_WIDTH          = 64,
    parameter int          VALUE_OFFSET         = 42,
    parameter logic [15:0] MATCH_UDP_PORT       = 16'h2710
) (
    input  logic                              axis_aclk,
    input  logic                              axis_reset,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    input  logic                              s_axis_tlast,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic                              m_axis_tlast,
    output logic [VALUE_WIDTH-1:0]            user_value,
    output logic                              user_value_valid,
    output logic [31:0]                       pkt_cnt,
    output logic [31:0]                       match_cnt
);

    localparam int KEEP_WIDTH  = C_S_AXIS_DATA_WIDTH / 8;
    localparam int SLICE_WIDTH = 1 + C_S_AXIS_TUSER_WIDTH + KEEP_WIDTH + C_S_AXIS_DATA_WIDTH;
    localparam int VALUE_BYTES = VALUE_WIDTH / 8;
    // Beat-1 relative byte positions of the port and value fields
    localparam int DPORT_B1    = UDP_DPORT_OFF - BEAT_BYTES;
    localparam int VALUE_B1    = VALUE_OFFSET - BEAT_BYTES;
    // Shortest packet that still carries the whole value field
    localparam logic [15:0] MIN_LEN = 16'(VALUE_OFFSET + VALUE_BYTES);

    rx_state_e              state_r;
    rx_state_e              state_nxt_s;
    logic [15:0]            ethertype_r;
    logic [7:0]             ipproto_r;
    logic [15:0]            pkt_len_r;
    logic [VALUE_WIDTH-1:0] user_value_r;
    logic                   user_value_valid_r;
    logic [31:0]            pkt_cnt_r;
    logic [31:0]            match_cnt_r;
    logic                   accept_s;
    logic                   match_s;
    logic [15:0]            dport_s;
    logic [VALUE_WIDTH-1:0] value_s;
    logic [SLICE_WIDTH-1:0] slice_in_s;
    logic [SLICE_WIDTH-1:0] slice_out_s;
    logic                   slice_ready_s;

    // ---------------- passthrough ----------------
    assign slice_in_s = {s_axis_tlast, s_axis_tuser, s_axis_tkeep, s_axis_tdata};

    axis_reg_slice #(
        .WIDTH (SLICE_WIDTH)
    ) u_slice (
        .clk       (axis_aclk),
        .rst       (axis_reset),
        .in_data   (slice_in_s),
        .in_valid  (s_axis_tvalid),
        .in_ready  (slice_ready_s),
        .out_data  (slice_out_s),
        .out_valid (m_axis_tvalid),
        .out_ready (m_axis_tready)
    );

    assign s_axis_tready = slice_ready_s;
    assign {m_axis_tlast, m_axis_tuser, m_axis_tkeep, m_axis_tdata} = slice_out_s;

    assign accept_s = s_axis_tvalid & slice_ready_s;

    // ---------------- parser ----------------
    // FSM state register
    always_ff @(posedge axis_aclk or posedge axis_reset) begin
        if (axis_reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state: walk beat 0, beat 1, then the body until tlast
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && !s_axis_tlast) begin
                    state_nxt_s = ST_HDR1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_HDR1: begin
                if (accept_s) begin
                    state_nxt_s = s_axis_tlast ? ST_IDLE : ST_BODY;
                end else begin
                    state_nxt_s = ST_HDR1;
                end
            end
            ST_BODY: begin
                if (accept_s && s_axis_tlast) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_BODY;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Beat-1 field extraction and match decision against latched beat-0 fields
    always_comb begin
        dport_s = {s_axis_tdata[8*DPORT_B1 +: 8], s_axis_tdata[8*(DPORT_B1+1) +: 8]};
        value_s = '0;
        for (int i = 0; i < VALUE_BYTES; i++) begin
            value_s[VALUE_WIDTH-1-8*i -: 8] = s_axis_tdata[8*(VALUE_B1+i) +: 8];
        end
        if (accept_s && (state_r == ST_HDR1)) begin
            match_s = (ethertype_r == ETHTYPE_IPV4) &&
                      (ipproto_r   == IPPROTO_UDP)  &&
                      (dport_s     == MATCH_UDP_PORT) &&
                      (pkt_len_r   >= MIN_LEN);
        end else begin
            match_s = 1'b0;
        end
    end

    // Latch beat-0 header fields
    always_ff @(posedge axis_aclk or posedge axis_reset) begin
        if (axis_reset) begin
            ethertype_r <= 16'h0000;
            ipproto_r   <= 8'h00;
            pkt_len_r   <= 16'h0000;
        end else if (accept_s && (state_r == ST_IDLE)) begin
            ethertype_r <= {s_axis_tdata[8*ETHTYPE_OFF +: 8], s_axis_tdata[8*(ETHTYPE_OFF+1) +: 8]};
            ipproto_r   <= s_axis_tdata[8*IPPROTO_OFF +: 8];
            pkt_len_r   <= s_axis_tuser[TUSER_LEN_MSB:TUSER_LEN_LSB];
        end
    end

    // Value output, one-cycle strobe and the two wrapping counters
    always_ff @(posedge axis_aclk or posedge axis_reset) begin
        if (axis_reset) begin
            user_value_r       <= '0;
            user_value_valid_r <= 1'b0;
            pkt_cnt_r          <= 32'd0;
            match_cnt_r        <= 32'd0;
        end else begin
            user_value_valid_r <= match_s;
            if (match_s) begin
                user_value_r <= value_s;
                match_cnt_r  <= match_cnt_r + 32'd1;
            end
            if (accept_s && s_axis_tlast) begin
                pkt_cnt_r <= pkt_cnt_r + 32'd1;
            end
        end
    end

    assign user_value       = user_value_r;
    assign user_value_valid = user_value_valid_r;
    assign pkt_cnt          = pkt_cnt_r;
    assign match_cnt        = match_cnt_r;

endmodule

// File: tb/tb_wombat_rx_parser.sv
// Directed self-checking bench for wombat_rx_parser.
`timescale 1ns/1ps
module tb_wombat_rx_parser;

    logic         axis_aclk;
    logic         axis_reset;
    logic [255:0] s_axis_tdata;
    logic [31:0]  s_axis_tkeep;
    logic [127:0] s_axis_tuser;
    logic         s_axis_tvalid;
    logic         s_axis_tready;
    logic         s_axis_tlast;
    logic [255:0] m_axis_tdata;
    logic [31:0]  m_axis_tkeep;
    logic [127:0] m_axis_tuser;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic         m_axis_tlast;
    logic [63:0]  user_value;
    logic         user_value_valid;
    logic [31:0]  pkt_cnt;
    logic [31:0]  match_cnt;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int pkt_seed = 0;
    bit bp_mode = 1'b0;

    logic [416:0] in_q[$];
    logic [416:0] out_q[$];
    int           in_cyc_q[$];
    int           out_cyc_q[$];
    int           exp_cyc_q[$];
    logic [63:0]  exp_val_q[$];
    int           str_cyc_q[$];
    logic [63:0]  str_val_q[$];

    wombat_rx_parser dut (
        .axis_aclk        (axis_aclk),
        .axis_reset       (axis_reset),
        .s_axis_tdata     (s_axis_tdata),
        .s_axis_tkeep     (s_axis_tkeep),
        .s_axis_tuser     (s_axis_tuser),
        .s_axis_tvalid    (s_axis_tvalid),
        .s_axis_tready    (s_axis_tready),
        .s_axis_tlast     (s_axis_tlast),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tkeep     (m_axis_tkeep),
        .m_axis_tuser     (m_axis_tuser),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tready    (m_axis_tready),
        .m_axis_tlast     (m_axis_tlast),
        .user_value       (user_value),
        .user_value_valid (user_value_valid),
        .pkt_cnt          (pkt_cnt),
        .match_cnt        (match_cnt)
    );

    // Clock
    initial begin
        axis_aclk = 1'b0;
        forever #5 axis_aclk = ~axis_aclk;
    end

    // Cycle counter
    always @(posedge axis_aclk) cyc <= cyc + 1;

    // Downstream ready: constant 1, or alternating when backpressure is on
    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge axis_aclk);
            #1;
            m_axis_tready = bp_mode ? ~m_axis_tready : 1'b1;
        end
    end

    // Output monitor: record egress beats and value strobes
    always @(negedge axis_aclk) begin
        if (m_axis_tvalid && m_axis_tready) begin
            out_q.push_back({m_axis_tlast, m_axis_tuser, m_axis_tkeep, m_axis_tdata});
            out_cyc_q.push_back(cyc);
        end
        if (user_value_valid) begin
            str_cyc_q.push_back(cyc);
            str_val_q.push_back(user_value);
        end
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_q();
        in_q.delete(); out_q.delete(); in_cyc_q.delete(); out_cyc_q.delete();
        exp_cyc_q.delete(); exp_val_q.delete(); str_cyc_q.delete(); str_val_q.delete();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ":ctl"}, 512'({s_axis_tready, m_axis_tvalid, m_axis_tlast, user_value_valid}), 512'(0));
        chk({tag, ":vals"}, 512'({user_value, pkt_cnt, match_cnt}), 512'(0));
        chk({tag, ":mdata"}, 512'({m_axis_tuser, m_axis_tkeep, m_axis_tdata}), 512'(0));
    endtask

    task automatic do_reset();
        s_axis_tvalid = 1'b0;
        bp_mode = 1'b0;
        axis_reset = 1'b1;
        repeat (2) @(posedge axis_aclk);
        @(negedge axis_aclk);
        chk_zero("rst");
        axis_reset = 1'b0;
        @(negedge axis_aclk);
        chk("rst:tready_up", 512'(s_axis_tready), 512'(1));
        clear_q();
        @(posedge axis_aclk);
        #1;
    endtask

    // Beat b of an nb-beat packet; header fields and value placed at their byte offsets
    function automatic logic [416:0] mk_beat(input int b, input int nb, input logic [15:0] len,
                                             input logic [15:0] etype, input logic [15:0] port,
                                             input logic [63:0] val);
        logic [255:0] d;
        logic [127:0] u;
        logic [31:0]  k;
        logic         l;
        for (int i = 0; i < 32; i++) d[8*i +: 8] = 8'(pkt_seed * 7 + b * 32 + i);
        if (b == 0) begin
            d[8*12 +: 8] = etype[15:8];
            d[8*13 +: 8] = etype[7:0];
            d[8*23 +: 8] = 8'h11;
        end
        if (b == 1) begin
            d[8*4 +: 8] = port[15:8];
            d[8*5 +: 8] = port[7:0];
            for (int i = 0; i < 8; i++) d[8*(10+i) +: 8] = val[63-8*i -: 8];
        end
        l = (b == nb - 1);
        u = {16'(pkt_seed), 96'hA5A5_A5A5_A5A5_A5A5_A5A5_A5A5, len};
        k = l ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        return {l, u, k, d};
    endfunction

    task automatic put_beat(input logic [416:0] bt, input bit gaps, input bit rec_str,
                            input logic [63:0] val);
        int  waited;
        bit  acc;
        if (gaps) begin
            int n;
            n = int'($urandom_range(0, 2));
            s_axis_tvalid = 1'b0;
            repeat (n) begin @(posedge axis_aclk); #1; end
        end
        {s_axis_tlast, s_axis_tuser, s_axis_tkeep, s_axis_tdata} = bt;
        s_axis_tvalid = 1'b1;
        acc = 1'b0;
        waited = 0;
        while (!acc && waited < 200) begin
            @(negedge axis_aclk);
            if (s_axis_tready) begin
                acc = 1'b1;
                in_q.push_back(bt);
                in_cyc_q.push_back(cyc);
                if (rec_str) begin
                    exp_cyc_q.push_back(cyc + 1);
                    exp_val_q.push_back(val);
                end
            end
            waited++;
            @(posedge axis_aclk);
            #1;
        end
        chk("accept", 512'(acc), 512'(1));
    endtask

    task automatic send_pkt(input int nb, input logic [15:0] len, input logic [15:0] etype,
                            input logic [15:0] port, input logic [63:0] val,
                            input bit gaps, input bit is_match);
        pkt_seed++;
        for (int b = 0; b < nb; b++) begin
            put_beat(mk_beat(b, nb, len, etype, port, val), gaps, is_match && (b == 1), val);
        end
        s_axis_tvalid = 1'b0;
    endtask

    task automatic check_test(input string nm, input int exp_pkts, input int exp_match,
                              input bit chk_lat, input bit chk_tput);
        int w;
        w = 0;
        while (out_q.size() < in_q.size() && w < 100) begin
            @(negedge axis_aclk);
            w++;
        end
        repeat (3) @(negedge axis_aclk);
        chk({nm, ":beats"}, 512'(out_q.size()), 512'(in_q.size()));
        for (int i = 0; i < in_q.size() && i < out_q.size(); i++) begin
            chk({nm, ":beat"}, 512'(out_q[i]), 512'(in_q[i]));
            if (chk_lat) chk({nm, ":lat"}, 512'(out_cyc_q[i]), 512'(in_cyc_q[i] + 1));
            if (chk_tput) chk({nm, ":tput"}, 512'(in_cyc_q[i]), 512'(in_cyc_q[0] + i));
        end
        chk({nm, ":strobes"}, 512'(str_cyc_q.size()), 512'(exp_cyc_q.size()));
        for (int i = 0; i < exp_cyc_q.size() && i < str_cyc_q.size(); i++) begin
            chk({nm, ":str_cyc"}, 512'(str_cyc_q[i]), 512'(exp_cyc_q[i]));
            chk({nm, ":str_val"}, 512'(str_val_q[i]), 512'(exp_val_q[i]));
        end
        if (exp_val_q.size() > 0) begin
            chk({nm, ":held_val"}, 512'(user_value), 512'(exp_val_q[exp_val_q.size()-1]));
        end
        chk({nm, ":pkt_cnt"}, 512'(pkt_cnt), 512'(exp_pkts));
        chk({nm, ":match_cnt"}, 512'(match_cnt), 512'(exp_match));
        clear_q();
    endtask

    initial begin
        axis_reset    = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tuser  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;

        // 1: basic match, 3 beats
        do_reset();
        send_pkt(3, 16'd96, 16'h0800, 16'h2710, 64'h0102030405060708, 1'b0, 1'b1);
        check_test("t1", 1, 1, 1'b1, 1'b0);
        chk("t1:user_value", 512'(user_value), 512'(64'h0102030405060708));

        // 2: wrong EtherType, wrong port
        do_reset();
        send_pkt(3, 16'd96, 16'h86DD, 16'h2710, 64'h1111111111111111, 1'b0, 1'b0);
        send_pkt(3, 16'd96, 16'h0800, 16'h2711, 64'h2222222222222222, 1'b0, 1'b0);
        check_test("t2", 2, 0, 1'b1, 1'b0);

        // 3: single-beat packet, too-short length, then boundary length 50 matches
        do_reset();
        send_pkt(1, 16'd32, 16'h0800, 16'h2710, 64'h3333333333333333, 1'b0, 1'b0);
        send_pkt(2, 16'd48, 16'h0800, 16'h2710, 64'h4444444444444444, 1'b0, 1'b0);
        send_pkt(2, 16'd50, 16'h0800, 16'h2710, 64'hDEADBEEFCAFEF00D, 1'b0, 1'b1);
        check_test("t3", 3, 1, 1'b1, 1'b0);

        // 4: backpressure and ingress gaps on a long packet
        do_reset();
        bp_mode = 1'b1;
        send_pkt(10, 16'd320, 16'h0800, 16'h2710, 64'h8877665544332211, 1'b1, 1'b1);
        check_test("t4", 1, 1, 1'b0, 1'b0);
        bp_mode = 1'b0;

        // 5: four back-to-back 2-beat matching packets at full rate
        do_reset();
        for (int p = 0; p < 4; p++) begin
            send_pkt(2, 16'd64, 16'h0800, 16'h2710, 64'hA0A1A2A3A4A5A6A0 + 64'(p), 1'b0, 1'b1);
        end
        check_test("t5", 4, 4, 1'b1, 1'b1);

        // 6: reset while beat 1 of a matching packet is presented
        do_reset();
        pkt_seed++;
        put_beat(mk_beat(0, 3, 16'd96, 16'h0800, 16'h2710, 64'h0F0E0D0C0B0A0908), 1'b0, 1'b0, 64'h0);
        {s_axis_tlast, s_axis_tuser, s_axis_tkeep, s_axis_tdata} =
            mk_beat(1, 3, 16'd96, 16'h0800, 16'h2710, 64'h0F0E0D0C0B0A0908);
        s_axis_tvalid = 1'b1;
        axis_reset = 1'b1;
        @(negedge axis_aclk);
        chk_zero("t6:rst");
        @(posedge axis_aclk);
        #1;
        s_axis_tvalid = 1'b0;
        @(negedge axis_aclk);
        axis_reset = 1'b0;
        @(negedge axis_aclk);
        chk("t6:tready_up", 512'(s_axis_tready), 512'(1));
        chk("t6:no_strobe", 512'(str_cyc_q.size()), 512'(0));
        clear_q();
        @(posedge axis_aclk);
        #1;
        send_pkt(2, 16'd64, 16'h0800, 16'h2710, 64'h5566778899AABBCC, 1'b0, 1'b1);
        check_test("t6", 1, 1, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
